// File: rtl/fp_denorm_shifter.sv
// fp_denorm_shifter
// Multicycle right-shift aligner: takes a 24-bit fraction and a 5-bit shift
// amount and produces a 27-bit value with guard/round/sticky positions,
// applying one binary stage (16, 8, 4, 2, 1) per clock.
//
// Optional feature macro: DENORM_STICKY_EN
//   defined   -> bit 0 accumulates the OR of every bit shifted out past it
//   undefined -> each stage is a plain logical right shift
// Latency, handshake and state behaviour are identical in both builds.
module fp_denorm_shifter (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] a,
    input  logic [4:0]  shamt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [26:0] b,
    output logic        out_zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] K_FIRST = 3'd4;

    state_t      state_reg, state_next;
    logic [26:0] r_reg, r_next;
    logic [4:0]  sh_reg, sh_next;
    logic [2:0]  k_reg, k_next;
    logic [26:0] b_reg, b_next;
    logic        out_zero_reg, out_zero_next;

    // Candidate result of every stage; the active one is chosen by k_reg.
    logic [4:0][26:0] stage_res;

    logic accept;
    logic last_step;
    logic handoff;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_stage
            localparam int S = 1 << gi;
            logic [26:0] shifted;
            assign shifted = r_reg >> S;
`ifdef DENORM_STICKY_EN
            // The old r[0] is inside r[S-1:0], so an earlier sticky survives.
            assign stage_res[gi] = {shifted[26:1], shifted[0] | (|r_reg[S-1:0])};
`else
            assign stage_res[gi] = shifted;
`endif
        end
    endgenerate

    assign accept    = (state_reg == IDLE) && in_valid;
    assign last_step = (state_reg == SHIFT) && (k_reg == 3'd0);
    assign handoff   = (state_reg == DONE) && out_ready;

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)    state_next = SHIFT;
            SHIFT:   if (last_step) state_next = DONE;
            DONE:    if (handoff)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs are pure functions of the state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_reg)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values: load on accept, one stage per SHIFT cycle,
    // and capture the result only on the step that enters DONE.
    always_comb begin
        r_next        = r_reg;
        sh_next       = sh_reg;
        k_next        = k_reg;
        b_next        = b_reg;
        out_zero_next = out_zero_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    r_next  = {a, 3'b000};
                    sh_next = shamt;
                    k_next  = K_FIRST;
                end
            end
            SHIFT: begin
                if (sh_reg[k_reg]) begin
                    r_next = stage_res[k_reg];
                end
                if (last_step) begin
                    // Park the counter at its start value rather than wrapping.
                    k_next        = K_FIRST;
                    b_next        = r_next;
                    out_zero_next = (r_next == 27'd0);
                end else begin
                    k_next = k_reg - 3'd1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg        <= 27'd0;
            sh_reg       <= 5'd0;
            k_reg        <= K_FIRST;
            b_reg        <= 27'd0;
            out_zero_reg <= 1'b0;
        end else begin
            r_reg        <= r_next;
            sh_reg       <= sh_next;
            k_reg        <= k_next;
            b_reg        <= b_next;
            out_zero_reg <= out_zero_next;
        end
    end

    assign b        = b_reg;
    assign out_zero = out_zero_reg;

endmodule

// File: tb/tb_fp_denorm_shifter.sv
// Directed testbench for fp_denorm_shifter. Expected values depend on
// whether DENORM_STICKY_EN is defined for the build.
module tb_fp_denorm_shifter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] a;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [26:0] b;
    logic        out_zero;

    int vectors     = 0;
    int miscompares = 0;
    int cnt;

    fp_denorm_shifter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .b         (b),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present an operand and let the accepting edge pass.
    task automatic issue(input logic [23:0] av, input logic [4:0] sv);
        cnt = 0;
        while (!in_ready && cnt < 20) begin
            tick();
            cnt++;
        end
        check("ready_before_issue", {31'd0, in_ready}, 32'd1);
        a        = av;
        shamt    = sv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("busy_after_accept", {31'd0, in_ready}, 32'd0);
    endtask

    // Count cycles until out_valid; the accept edge has already passed.
    task automatic await_done();
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        check("latency", cnt, 32'd5);
    endtask

    task automatic check_result(input string tag, input logic [26:0] eb, input logic ez);
        check({tag, "_b"}, {5'd0, b}, {5'd0, eb});
        check({tag, "_zero"}, {31'd0, out_zero}, {31'd0, ez});
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        $display("op %-10s a=0x%06h shamt=%0d -> b=0x%07h out_zero=%0d", tag, a, shamt, b, out_zero);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("after_handoff_in_ready", {31'd0, in_ready}, 32'd1);
        check("after_handoff_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [23:0] av, input logic [4:0] sv,
                          input logic [26:0] eb, input logic ez);
        issue(av, sv);
        await_done();
        check_result(tag, eb, ez);
        release_result();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 24'd0;
        shamt     = 5'd0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_b", {5'd0, b}, 32'd0);
        check("reset_zero", {31'd0, out_zero}, 32'd0);

        // Zero shift
        run_op("zero_sh", 24'h800000, 5'd0, 27'h4000000, 1'b0);

        // Sticky capture and saturating shifts
`ifdef DENORM_STICKY_EN
        run_op("sticky", 24'hC00001, 5'd4, 27'h0600001, 1'b0);
        run_op("sat31", 24'hFFFFFF, 5'd31, 27'h0000001, 1'b0);
        run_op("sat27", 24'h800000, 5'd27, 27'h0000001, 1'b0);
        run_op("lsb_out", 24'h000001, 5'd4, 27'h0000001, 1'b0);
`else
        run_op("sticky", 24'hC00001, 5'd4, 27'h0600000, 1'b0);
        run_op("sat31", 24'hFFFFFF, 5'd31, 27'h0000000, 1'b1);
        run_op("sat27", 24'h800000, 5'd27, 27'h0000000, 1'b1);
        run_op("lsb_out", 24'h000001, 5'd4, 27'h0000000, 1'b1);
`endif
        run_op("sh26", 24'h800000, 5'd26, 27'h0000001, 1'b0);
        run_op("zero_in", 24'h000000, 5'd7, 27'h0000000, 1'b1);

        // Backpressure: result held stable while out_ready is low
        issue(24'h800000, 5'd1);
        await_done();
        check_result("backpress", 27'h2000000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_b", {5'd0, b}, 32'h2000000);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        release_result();

        // Ignored input during SHIFT
        issue(24'h800000, 5'd2);
        a        = 24'hFFFFFF;
        shamt    = 5'd0;
        in_valid = 1'b1;
        check("ignore_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        in_valid = 1'b0;
        a        = 24'h800000;
        shamt    = 5'd2;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        check("ignore_latency", cnt, 32'd4);
        check_result("ignored", 27'h1000000, 1'b0);
        release_result();

        // Reset asserted on the third SHIFT cycle
        issue(24'hFFFFFF, 5'd3);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_b", {5'd0, b}, 32'd0);
        check("midrst_zero", {31'd0, out_zero}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        run_op("fresh", 24'h000003, 5'd1, 27'h000000C, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fp_denorm_shifter.md
# fp_denorm_shifter

Multicycle right-shift aligner for the pipelined FPU. It is the inverse of the leading-zero normalizing left shifter. It takes a 24-bit fraction and a 5-bit shift amount and produces the fraction right-shifted into a 27-bit result with guard, round and sticky positions, ready for the rounding stage. It processes one binary stage (16/8/4/2/1) per clock behind a valid/ready handshake, so it can sit between exponent-difference logic and the adder or rounder without a wide barrel shifter.

## Interface
Parameters:
- none; widths are fixed at 24-bit fraction in, 5-bit shift amount, 27-bit result out.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request carries a valid operand.
- in_ready  output  1  block accepts an operand this cycle.
- a  input  24  fraction to denormalize; bit 23 is the MSB or hidden bit.
- shamt  input  5  right-shift amount, 0..31.
- out_valid  output  1  result b and out_zero are valid.
- out_ready  input  1  consumer accepts the result.
- b  output  27  shifted value; bits 26:3 are the fraction, bit 2 is guard, bit 1 is round, bit 0 is sticky.
- out_zero  output  1  b equals 27'b0.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready is 1.
  - On in_valid&in_ready: working register r <= {a,3'b000}, sh <= shamt, stage counter k <= 4, go to SHIFT.
- SHIFT:
  - in_ready is 0.
  - Each cycle, if sh[k] is set, r <= r >> 2^k; otherwise r is unchanged.
  - k decrements each cycle. After the k=0 step, go to DONE and load b <= the final r and out_zero <= (final r == 0).
- Sticky rule (with DENORM_STICKY_EN):
  - In each shifting stage of s bits, the new r[0] = (r>>s)[0] | (|r[s-1:0]).
  - The previous sticky is therefore never lost.
- Shifts of 27 or more yield fraction, guard and round all zero. With sticky enabled, b[0] = |a.
- DONE:
  - out_valid is 1. b and out_zero are held stable.
  - On out_ready, go to IDLE.
  - in_ready stays 0 in DONE, so no accept happens in the same cycle as the result handoff.
- in_valid while in_ready=0 is ignored. The upstream block must hold the request until in_ready is 1.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, b=0, out_zero=0, r=0, k=4.
- Acceptance at edge E0. Stages 16, 8, 4, 2, 1 are applied at edges E1..E5.
- out_valid is high from E5 onward. Latency is 5 cycles from accept to out_valid.
- Handoff: on the edge where out_valid&out_ready, go to IDLE. in_ready rises after that edge. Minimum issue interval is 7 cycles.
- Latency is fixed at 5 cycles regardless of shamt, including shamt=0.
- rst=1 during any state:
  - At the next edge, return to reset values. Any in-flight operation is discarded with no partial out_valid.
  - rst takes priority over in_valid and out_ready in the same cycle.
- b and out_zero change only on the edge entering DONE (and on reset).

## Configuration
- Macro DENORM_STICKY_EN.
- Defined:
  - Bit 0 accumulates the OR of all bits shifted out past position 0, as specified above.
  - out_zero is 0 whenever any nonzero bit of a was shifted out.
- Undefined:
  - Each stage is a plain logical right shift. Shifted-out bits are dropped and b[0] is just the shifted bit.
  - Latency, handshake and state behaviour are identical to the defined case.

## Test plan
- Zero shift: a=0x800000, shamt=0 -> out_valid 5 cycles after accept, b=0x4000000, out_zero=0.
- Sticky capture: a=0xC00001, shamt=4 -> b=0x0600001 with DENORM_STICKY_EN, b=0x0600000 without it.
- Saturating shift: a=0xFFFFFF, shamt=31 -> b=0x0000001 and out_zero=0 with DENORM_STICKY_EN; b=0 and out_zero=1 without it.
- Backpressure: after a=0x800000, shamt=1 completes, hold out_ready=0 for 10 cycles -> out_valid=1 and b=0x2000000 stable, in_ready=0 throughout. Raise out_ready -> in_ready=1 the following cycle.
- Ignored input: pulse in_valid with new operands while in SHIFT -> no effect, and the original result is delivered.
- Reset mid-operation: assert rst on the third SHIFT cycle -> after the next edge state is IDLE, out_valid=0, b=0, in_ready=1. A fresh a=0x000003, shamt=1 then yields b=0x000000C.
